lane_grant_sequencer: RTL and testbench
=======================================

Name: lane_grant_sequencer

Overview:
Registered, parametrised lane-grant controller. Takes the index of the busiest lane and sequences the lights for that lane through green, yellow and all-red phases. Drives one-hot green and yellow vectors for NUM_LANES approaches. It sits downstream of the lane-count comparator and replaces the bare combinational one-hot lane decode.

Parameters:
NUM_LANES, 4, number of approaches; must be >=2 and <=2^SEL_W.
SEL_W, 2, width of the lane index.
GREEN_CYCLES, 8, length of one green window in clocks; must be >=1.
YELLOW_CYCLES, 3, length of the yellow phase in clocks; must be >=1.
ALLRED_CYCLES, 2, length of the all-red clearance in clocks; must be >=1.
MAX_EXTEND, 2, maximum number of green-window re-arms for the same lane; 0 disables extension.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
largest_valid  in  1  largest carries a meaningful lane index.
largest  in  SEL_W  index of the busiest lane (0=N, 1=E, 2=S, 3=W for the default).
green  out  NUM_LANES  one-hot green for active_lane; all zero outside GREEN.
yellow  out  NUM_LANES  one-hot yellow for active_lane; all zero outside YELLOW.
all_red  out  1  high only in ALL_RED.
active_lane  out  SEL_W  lane currently or most recently granted.
switch_pulse  out  1  high for exactly the first cycle of each fresh (non-extended) green.

Behaviour:
- The clock and reset are decided: one clock (clk); reset is synchronous and active-high (reset).
- All outputs are registered. The FSM has states ALL_RED, GREEN and YELLOW, and a down-counter timer.
- A state loaded with N lasts exactly N cycles: timer runs N-1 down to 0, and the transition is taken on the cycle timer==0.
- Reset values: state=ALL_RED, timer=ALLRED_CYCLES-1, green=0, yellow=0, all_red=1, active_lane=0, switch_pulse=0, ext_cnt=0.
- ALL_RED:
  - At timer==0, largest is sampled. It is accepted only if largest_valid=1 and largest<NUM_LANES.
  - Accepted: the next cycle enters GREEN with active_lane=largest, timer=GREEN_CYCLES-1, ext_cnt=0, switch_pulse=1.
  - Not accepted: stay in ALL_RED with timer held at 0 and re-sample every cycle. There is no round-robin fallback.
- GREEN:
  - green = one-hot(active_lane). largest is ignored except on the timer==0 cycle.
  - At timer==0, if largest_valid=1, largest==active_lane and ext_cnt<MAX_EXTEND: reload timer=GREEN_CYCLES-1 and increment ext_cnt. The state stays GREEN and switch_pulse stays 0.
  - Otherwise go to YELLOW with timer=YELLOW_CYCLES-1.
- YELLOW: yellow = one-hot(active_lane). At timer==0 go to ALL_RED with timer=ALLRED_CYCLES-1.
- active_lane changes only on ALL_RED->GREEN and holds its value through YELLOW and ALL_RED.
- No cycle has more than one of {green!=0, yellow!=0, all_red} active. green and yellow are never multi-hot.
- Same-lane re-grant after YELLOW is allowed and still passes through ALL_RED first.
- Maximum continuous green for one lane is GREEN_CYCLES*(MAX_EXTEND+1).
- Reset asserted in any state, on any cycle, wins: the next edge forces the reset values, and any extension count is discarded.

Test Plan:
- Defaults, reset released with largest_valid=1, largest=2 held, then largest=1 after the first green starts -> all_red for 2 cycles. Then green=0100 with switch_pulse=1 on its first cycle only. Green lasts 8 cycles (no extension, since largest!=active_lane at timer 0), then yellow=0100 for 3 cycles, then all_red for 2 cycles, then green=0010.
- Defaults, largest=2 valid held constantly -> green=0100 continuously for 24 cycles with a single switch_pulse, then yellow for 3 and all_red for 2. Then green=0100 again with a new switch_pulse.
- largest_valid=0 after reset for 20 cycles -> all_red=1 and green=yellow=0 throughout. Assert valid with largest=3 -> green=1000 on the following cycle.
- NUM_LANES=3, SEL_W=2, largest=3 valid -> stays in all_red indefinitely. Change to largest=0 -> green=001 next cycle.
- reset pulsed for 1 cycle on the 5th green cycle of lane 1 -> next cycle all_red=1, green=0, active_lane=0. A fresh 2-cycle all-red precedes the next grant.
- MAX_EXTEND=0, largest=1 held -> green=0010 for exactly 8 cycles per grant, with yellow/all_red between successive grants.

Source files
------------

// File: rtl/lane_grant_sequencer.sv
// ============================================================================
// Module   : lane_grant_sequencer
// Brief    : Registered green/yellow/all-red sequencer for the busiest lane.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_grant_sequencer #(
    parameter int NUM_LANES     = 4,
    parameter int SEL_W         = 2,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int MAX_EXTEND    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 largest_valid,
    input  logic [SEL_W-1:0]     largest,
    output logic [NUM_LANES-1:0] green,
    output logic [NUM_LANES-1:0] yellow,
    output logic                 all_red,
    output logic [SEL_W-1:0]     active_lane,
    output logic                 switch_pulse
);

    localparam int C_MAX_LEN_GY = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    localparam int C_MAX_LEN    = (C_MAX_LEN_GY > ALLRED_CYCLES) ? C_MAX_LEN_GY : ALLRED_CYCLES;
    localparam int TW           = (C_MAX_LEN > 1) ? $clog2(C_MAX_LEN) : 1;
    localparam int EW           = (MAX_EXTEND > 0) ? $clog2(MAX_EXTEND + 1) : 1;

    localparam logic [TW-1:0] C_GREEN_LOAD  = TW'(GREEN_CYCLES - 1);
    localparam logic [TW-1:0] C_YELLOW_LOAD = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] C_ALLRED_LOAD = TW'(ALLRED_CYCLES - 1);

    localparam logic [1:0] S_ALL_RED = 2'd0;
    localparam logic [1:0] S_GREEN   = 2'd1;
    localparam logic [1:0] S_YELLOW  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [EW-1:0]        ext_cnt_q, ext_cnt_d;
    logic [SEL_W-1:0]     lane_q, lane_d;
    logic [NUM_LANES-1:0] green_q, green_d;
    logic [NUM_LANES-1:0] yellow_q, yellow_d;
    logic                 all_red_q, all_red_d;
    logic                 pulse_q, pulse_d;

    logic w_timer_done;
    logic w_sel_in_range;
    logic w_ext_allowed;
    logic [NUM_LANES-1:0] w_onehot;

    assign w_timer_done   = (timer_q == '0);
    assign w_sel_in_range = (32'(largest) < NUM_LANES);
    assign w_ext_allowed  = (32'(ext_cnt_q) < MAX_EXTEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_ALL_RED;
            timer_q   <= C_ALLRED_LOAD;
            ext_cnt_q <= '0;
            lane_q    <= '0;
            green_q   <= '0;
            yellow_q  <= '0;
            all_red_q <= 1'b1;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ext_cnt_q <= ext_cnt_d;
            lane_q    <= lane_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            all_red_q <= all_red_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ext_cnt_d = ext_cnt_q;
        lane_d    = lane_q;
        case (state_q)
            S_ALL_RED: begin
                // With no acceptable request the timer parks at zero and re-samples.
                if (w_timer_done) begin
                    if (largest_valid && w_sel_in_range) begin
                        state_d   = S_GREEN;
                        timer_d   = C_GREEN_LOAD;
                        ext_cnt_d = '0;
                        lane_d    = largest;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GREEN: begin
                if (w_timer_done) begin
                    if (largest_valid && (largest == lane_q) && w_ext_allowed) begin
                        timer_d   = C_GREEN_LOAD;
                        ext_cnt_d = ext_cnt_q + EW'(1);
                    end else begin
                        state_d = S_YELLOW;
                        timer_d = C_YELLOW_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_YELLOW: begin
                if (w_timer_done) begin
                    state_d = S_ALL_RED;
                    timer_d = C_ALLRED_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_ALL_RED;
                timer_d = C_ALLRED_LOAD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    assign w_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_d;

    always_comb begin
        green_d   = '0;
        yellow_d  = '0;
        all_red_d = 1'b0;
        pulse_d   = (state_q == S_ALL_RED) && (state_d == S_GREEN);
        case (state_d)
            S_GREEN:  green_d   = w_onehot;
            S_YELLOW: yellow_d  = w_onehot;
            default:  all_red_d = 1'b1;
        endcase
    end

    assign green        = green_q;
    assign yellow       = yellow_q;
    assign all_red      = all_red_q;
    assign active_lane  = lane_q;
    assign switch_pulse = pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_grant_sequencer.sv
// ============================================================================
// Module   : tb_lane_grant_sequencer
// Brief    : Three parameter variants checked against a phase/elapsed-time model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_grant_sequencer;

    localparam int G = 8;
    localparam int Y = 3;
    localparam int A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       v[3];
    logic [1:0] s[3];

    logic [3:0] g0, y0, g2, y2;
    logic [2:0] g1, y1;
    logic       ar0, ar1, ar2, sp0, sp1, sp2;
    logic [1:0] al0, al1, al2;

    lane_grant_sequencer u_dut0 (
        .clk(clk), .reset(rst), .largest_valid(v[0]), .largest(s[0]),
        .green(g0), .yellow(y0), .all_red(ar0), .active_lane(al0), .switch_pulse(sp0));

    lane_grant_sequencer #(.NUM_LANES(3)) u_dut1 (
        .clk(clk), .reset(rst), .largest_valid(v[1]), .largest(s[1]),
        .green(g1), .yellow(y1), .all_red(ar1), .active_lane(al1), .switch_pulse(sp1));

    lane_grant_sequencer #(.MAX_EXTEND(0)) u_dut2 (
        .clk(clk), .reset(rst), .largest_valid(v[2]), .largest(s[2]),
        .green(g2), .yellow(y2), .all_red(ar2), .active_lane(al2), .switch_pulse(sp2));

    int c_nl[3] = '{4, 3, 4};
    int c_mx[3] = '{2, 2, 0};

    // Model: phase 0=all-red 1=green 2=yellow, el = 1-based cycle index in phase,
    // win = number of green windows granted so far in this green.
    int m_ph[3], m_el[3], m_lane[3], m_win[3];
    bit m_pulse[3];

    int checks = 0;
    int failures = 0;

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            m_pulse[i] = 1'b0;
            if (rst) begin
                m_ph[i] = 0; m_el[i] = 1; m_lane[i] = 0; m_win[i] = 0;
            end else if (m_ph[i] == 0) begin
                if (m_el[i] >= A && v[i] && int'(s[i]) < c_nl[i]) begin
                    m_ph[i] = 1; m_el[i] = 1; m_lane[i] = int'(s[i]); m_win[i] = 1; m_pulse[i] = 1'b1;
                end else begin
                    m_el[i]++;
                end
            end else if (m_ph[i] == 1) begin
                if (m_el[i] == G * m_win[i]) begin
                    if (v[i] && int'(s[i]) == m_lane[i] && m_win[i] <= c_mx[i]) begin
                        m_win[i]++; m_el[i]++;
                    end else begin
                        m_ph[i] = 2; m_el[i] = 1;
                    end
                end else begin
                    m_el[i]++;
                end
            end else begin
                if (m_el[i] >= Y) begin
                    m_ph[i] = 0; m_el[i] = 1;
                end else begin
                    m_el[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [11:0] obs(int i);
        case (i)
            0:       return {g0, y0, ar0, al0, sp0};
            1:       return {1'b0, g1, 1'b0, y1, ar1, al1, sp1};
            default: return {g2, y2, ar2, al2, sp2};
        endcase
    endfunction

    function automatic logic [11:0] expv(int i);
        logic [3:0] oh;
        oh = 4'(1 << m_lane[i]);
        return {(m_ph[i] == 1) ? oh : 4'b0, (m_ph[i] == 2) ? oh : 4'b0,
                m_ph[i] == 0, 2'(m_lane[i]), m_pulse[i]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; s[i] = 2'd0; end
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
                failures++;
                $display("FAIL reset_model inst=%0d got=%h exp=%h", i, obs(i), expv(i));
            end
        end
        checks++;
        if ({g0, y0, ar0, al0, sp0} !== 12'b0000_0000_1_00_0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=000000001000", {g0, y0, ar0, al0, sp0});
        end
    endtask

    task automatic test_grant_sequence();
        int  n_g2 = 0;
        bit  seen_l1 = 0;
        bit  switched = 0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin v[i] = 1'b1; s[i] = 2'd2; end
        for (int k = 0; k < 40; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL grant_seq inst=%0d t=%0t got=%h exp=%h", i, $time, obs(i), expv(i));
                end
            end
            if (g0 === 4'b0100) n_g2++;
            if (g0 === 4'b0010) seen_l1 = 1;
            if (sp0 === 1'b1 && !switched) begin s[0] = 2'd1; switched = 1; end
        end
        checks++;
        if (n_g2 !== 8) begin
            failures++;
            $display("FAIL grant_green_len got=%0d exp=8", n_g2);
        end
        checks++;
        if (!seen_l1) begin
            failures++;
            $display("FAIL grant_next_lane got=no_0010 exp=0010");
        end
    endtask

    task automatic test_extend();
        int  run0 = 0, run2 = 0, pulses = 0;
        bit  y_seen0 = 0, y_seen2 = 0;
        rst = 1'b1; step(); rst = 1'b0;
        v[0] = 1'b1; s[0] = 2'd2;
        v[1] = 1'b0; s[1] = 2'd0;
        v[2] = 1'b1; s[2] = 2'd1;
        for (int k = 0; k < 32; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL extend inst=%0d t=%0t got=%h exp=%h", i, $time, obs(i), expv(i));
                end
            end
            if (y0 !== 4'b0) y_seen0 = 1;
            if (y2 !== 4'b0) y_seen2 = 1;
            if (!y_seen0 && g0 === 4'b0100) run0++;
            if (!y_seen2 && g2 === 4'b0010) run2++;
            if (sp0 === 1'b1) pulses++;
        end
        checks++;
        if (run0 !== 24) begin
            failures++;
            $display("FAIL extend_max_green got=%0d exp=24", run0);
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL extend_pulses got=%0d exp=2", pulses);
        end
        checks++;
        if (run2 !== 8) begin
            failures++;
            $display("FAIL noext_green got=%0d exp=8", run2);
        end
    endtask

    task automatic test_idle_and_range();
        rst = 1'b1; step(); rst = 1'b0;
        v[0] = 1'b0; s[0] = 2'd3;
        v[1] = 1'b1; s[1] = 2'd3;
        v[2] = 1'b0; s[2] = 2'd0;
        for (int k = 0; k < 20; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL idle inst=%0d t=%0t got=%h exp=%h", i, $time, obs(i), expv(i));
                end
            end
        end
        checks++;
        if ({ar0, ar1, g0, g1} !== {1'b1, 1'b1, 4'b0, 3'b0}) begin
            failures++;
            $display("FAIL idle_allred got=%b exp=11_0000_000", {ar0, ar1, g0, g1});
        end
        v[0] = 1'b1; s[1] = 2'd0;
        step();
        checks++;
        if (g0 !== 4'b1000) begin
            failures++;
            $display("FAIL idle_grant got=%b exp=1000", g0);
        end
        checks++;
        if (g1 !== 3'b001) begin
            failures++;
            $display("FAIL range_grant got=%b exp=001", g1);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int n_ar = 0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin v[i] = 1'b1; s[i] = 2'd1; end
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (sp0 === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rmid_wait got=timeout exp=switch_pulse");
        end
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({ar0, g0, al0} !== {1'b1, 4'b0, 2'b0}) begin
            failures++;
            $display("FAIL rmid_state got=%b exp=1000000", {ar0, g0, al0});
        end
        n_ar = 1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL rmid inst=%0d t=%0t got=%h exp=%h", i, $time, obs(i), expv(i));
                end
            end
            if (g0 !== 4'b0) found = 1;
            else if (ar0 === 1'b1) n_ar++;
        end
        checks++;
        if (!found || n_ar !== 2) begin
            failures++;
            $display("FAIL rmid_allred_len got=%0d exp=2", n_ar);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = ($urandom_range(0, 99) < 85);
                s[i] = 2'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 99) < 2);
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL random inst=%0d t=%0t got=%h exp=%h", i, $time, obs(i), expv(i));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; s[i] = 2'd0; end
        test_reset();
        test_grant_sequence();
        test_extend();
        test_idle_and_range();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
